// File: rtl/mmss_timer_ctrl.sv
// MM:SS timer controller: four loadable BCD up/down digits sequenced as one
// time display, with a one-second prescaler and a start/stop/clear state machine.

module mmss_bcd_digit (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       en_i,
  input  logic       up_i,
  input  logic       ld_i,
  input  logic [3:0] ld_val_i,
  output logic [3:0] q_o,
  output logic       co_o
);

  logic [3:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld_i) begin
      q_d = ld_val_i;
    end else if (en_i) begin
      if (up_i) begin
        q_d = (q_q >= 4'd9) ? 4'd0 : q_q + 4'd1;
      end else begin
        q_d = (q_q == 4'd0 || q_q > 4'd9) ? 4'd9 : q_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o  = q_q;
  assign co_o = en_i && (up_i ? (q_q == 4'd9) : (q_q == 4'd0));

endmodule

module mmss_timer_ctrl #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       up,
  input  logic       load_preset,
  input  logic [7:0] preset_mm,
  input  logic [7:0] preset_ss,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       running,
  output logic       done
);

  localparam int PSC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [PSC_W-1:0] psc_q;
  logic             dir_q;
  logic             running_q;
  logic             done_q;

  logic [3:0] dig_q  [4];
  logic [3:0] ld_val [4];
  logic [3:0] dig_en;
  logic [3:0] dig_ld;
  logic [3:0] dig_co;

  logic cmd_load;
  logic psc_wrap;
  logic tick_run;
  logic at_max;
  logic at_zero;
  logic one_left;
  logic count_step;
  logic st_wrap;

  // Digit order: 0 = seconds units, 1 = seconds tens, 2 = minutes units, 3 = minutes tens
  for (genvar g = 0; g < 4; g++) begin : g_digit
    mmss_bcd_digit u_digit (
      .clk_i    (clk),
      .reset_i  (reset),
      .en_i     (dig_en[g]),
      .up_i     (dir_q),
      .ld_i     (dig_ld[g]),
      .ld_val_i (ld_val[g]),
      .q_o      (dig_q[g]),
      .co_o     (dig_co[g])
    );
  end

  assign cmd_load   = load_preset && (state_q != S_RUN);
  assign psc_wrap   = (psc_q == PSC_LAST);
  assign tick_run   = (state_q == S_RUN) && psc_wrap && !stop && !clear;
  assign at_max     = ({dig_q[3], dig_q[2], dig_q[1], dig_q[0]} == 16'h9959);
  assign at_zero    = ({dig_q[3], dig_q[2], dig_q[1], dig_q[0]} == 16'h0000);
  assign one_left   = ({dig_q[3], dig_q[2], dig_q[1], dig_q[0]} == 16'h0001);
  assign count_step = tick_run && (dir_q ? !at_max : !at_zero);

  // Seconds tens is mod-6: its wrap is a load, and that load also carries upward
  assign st_wrap = dig_co[0] && (dig_q[1] == (dir_q ? 4'd5 : 4'd0));

  always_comb begin
    dig_en = 4'b0000;
    dig_ld = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      ld_val[i] = 4'd0;
    end
    if (clear) begin
      dig_ld = 4'b1111;
    end else if (cmd_load) begin
      dig_ld    = 4'b1111;
      ld_val[0] = (preset_ss[3:0] > 4'd9) ? 4'd9 : preset_ss[3:0];
      ld_val[1] = (preset_ss[7:4] > 4'd5) ? 4'd5 : preset_ss[7:4];
      ld_val[2] = (preset_mm[3:0] > 4'd9) ? 4'd9 : preset_mm[3:0];
      ld_val[3] = (preset_mm[7:4] > 4'd9) ? 4'd9 : preset_mm[7:4];
    end else if (count_step) begin
      dig_en[0] = 1'b1;
      dig_en[1] = dig_co[0] && !st_wrap;
      dig_ld[1] = st_wrap;
      ld_val[1] = dir_q ? 4'd0 : 4'd5;
      dig_en[2] = st_wrap;
      dig_en[3] = dig_co[2];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      psc_q     <= '0;
      dir_q     <= 1'b1;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clear || cmd_load) begin
        state_q   <= S_IDLE;
        psc_q     <= '0;
        running_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            psc_q <= '0;
            if (start && !stop) begin
              dir_q <= up;
              if (!up && at_zero) begin
                state_q   <= S_DONE;
                done_q    <= 1'b1;
                running_q <= 1'b0;
              end else begin
                state_q   <= S_RUN;
                running_q <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (stop) begin
              state_q   <= S_PAUSE;
              psc_q     <= '0;
              running_q <= 1'b0;
            end else if (psc_wrap) begin
              psc_q <= '0;
              // Up ends on a tick at 99:59; down ends on the tick that reaches 00:00
              if (dir_q ? at_max : (at_zero || one_left)) begin
                state_q   <= S_DONE;
                done_q    <= 1'b1;
                running_q <= 1'b0;
              end
            end else begin
              psc_q <= psc_q + PSC_W'(1);
            end
          end
          S_PAUSE: begin
            psc_q <= '0;
            if (start && !stop) begin
              state_q   <= S_RUN;
              running_q <= 1'b1;
            end
          end
          default: begin
            psc_q <= '0;
          end
        endcase
      end
    end
  end

  assign mm      = {dig_q[3], dig_q[2]};
  assign ss      = {dig_q[1], dig_q[0]};
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_mmss_timer_ctrl.sv
// Bench for mmss_timer_ctrl: a seconds-count model checked every cycle,
// plus directed scenarios with literal expected values.

module tb_mmss_timer_ctrl;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       up = 1'b1;
  logic       load_preset = 1'b0;
  logic [7:0] preset_mm = 8'h00;
  logic [7:0] preset_ss = 8'h00;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       running;
  logic       done;

  int vectors = 0;
  int miscompares = 0;

  mmss_timer_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .up          (up),
    .load_preset (load_preset),
    .preset_mm   (preset_mm),
    .preset_ss   (preset_ss),
    .mm          (mm),
    .ss          (ss),
    .running     (running),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Model: the time is a plain count of seconds, 0..5999
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  localparam int MAX_SECS = 99 * 60 + 59;
  int m_state = M_IDLE;
  int m_secs  = 0;
  int m_psc   = 0;
  bit m_dir   = 1'b1;
  bit m_done  = 1'b0;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] t;
    t[7:4] = 4'(v / 10);
    t[3:0] = 4'(v % 10);
    return t;
  endfunction

  function automatic int lim(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_state = M_IDLE; m_secs = 0; m_psc = 0; m_dir = 1'b1; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (clear) begin
        m_state = M_IDLE; m_secs = 0; m_psc = 0;
      end else if (load_preset && m_state != M_RUN) begin
        m_state = M_IDLE; m_psc = 0;
        m_secs = (lim(int'(preset_mm[7:4]), 9) * 10 + lim(int'(preset_mm[3:0]), 9)) * 60
               + lim(int'(preset_ss[7:4]), 5) * 10 + lim(int'(preset_ss[3:0]), 9);
      end else if (m_state == M_IDLE) begin
        if (start && !stop) begin
          m_dir = up;
          if (!up && m_secs == 0) begin
            m_state = M_DONE; m_done = 1'b1;
          end else begin
            m_state = M_RUN;
          end
        end
      end else if (m_state == M_RUN) begin
        if (stop) begin
          m_state = M_PAUSE; m_psc = 0;
        end else if (m_psc == TICK_DIV - 1) begin
          m_psc = 0;
          if (m_dir) begin
            if (m_secs == MAX_SECS) begin
              m_state = M_DONE; m_done = 1'b1;
            end else begin
              m_secs++;
            end
          end else begin
            if (m_secs > 0) m_secs--;
            if (m_secs == 0) begin
              m_state = M_DONE; m_done = 1'b1;
            end
          end
        end else begin
          m_psc++;
        end
      end else if (m_state == M_PAUSE) begin
        if (start && !stop) m_state = M_RUN;
      end
    end
    #1;
    vectors++;
    if (mm !== to_bcd(m_secs / 60) || ss !== to_bcd(m_secs % 60) ||
        running !== (m_state == M_RUN) || done !== m_done) begin
      miscompares++;
      $display("FAIL model t=%0t: got mm=%h ss=%h running=%b done=%b, want mm=%h ss=%h running=%b done=%b",
               $time, mm, ss, running, done, to_bcd(m_secs / 60), to_bcd(m_secs % 60),
               (m_state == M_RUN), m_done);
    end
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go(input bit s, input bit sp, input bit c, input bit l);
    start = s; stop = sp; clear = c; load_preset = l;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; clear = 1'b0; load_preset = 1'b0;
  endtask

  task automatic load(input logic [7:0] pm, input logic [7:0] ps);
    preset_mm = pm; preset_ss = ps;
    go(0, 0, 0, 1);
  endtask

  initial begin
    step(2);
    reset = 1'b0;
    // Reset values and first-tick latency
    check8("reset_mm", mm, 8'h00);
    check8("reset_ss", ss, 8'h00);
    check1("reset_running", running, 1'b0);
    check1("reset_done", done, 1'b0);
    up = 1'b1;
    go(1, 0, 0, 0);
    check1("running_after_start", running, 1'b1);
    step(3);
    check8("ss_before_first_tick", ss, 8'h00);
    step(1);
    check8("ss_first_tick", ss, 8'h01);
    go(0, 0, 1, 0);

    // Seconds-tens rollover
    load(8'h00, 8'h59); up = 1'b1; go(1, 0, 0, 0); step(4);
    check8("roll_0059_mm", mm, 8'h01);
    check8("roll_0059_ss", ss, 8'h00);
    go(0, 0, 1, 0);
    load(8'h09, 8'h59); go(1, 0, 0, 0); step(4);
    check8("roll_0959_mm", mm, 8'h10);
    check8("roll_0959_ss", ss, 8'h00);
    go(0, 0, 1, 0);
    load(8'h10, 8'h00); up = 1'b0; go(1, 0, 0, 0); step(4);
    check8("down_1000_mm", mm, 8'h09);
    check8("down_1000_ss", ss, 8'h59);
    go(0, 0, 1, 0);

    // Down to zero
    load(8'h00, 8'h02); up = 1'b0; go(1, 0, 0, 0); step(4);
    check8("down_0001_ss", ss, 8'h01);
    check1("down_0001_done", done, 1'b0);
    step(4);
    check8("down_zero_ss", ss, 8'h00);
    check1("down_zero_done", done, 1'b1);
    check1("down_zero_running", running, 1'b0);
    step(1);
    check1("down_done_pulse_end", done, 1'b0);
    go(1, 0, 0, 0); step(3);
    check8("done_start_ignored_ss", ss, 8'h00);
    check1("done_start_ignored_running", running, 1'b0);
    go(0, 0, 1, 0);

    // Up saturation
    load(8'h99, 8'h58); up = 1'b1; go(1, 0, 0, 0); step(4);
    check8("sat_9959_ss", ss, 8'h59);
    step(4);
    check1("sat_done", done, 1'b1);
    check8("sat_mm", mm, 8'h99);
    check8("sat_ss", ss, 8'h59);
    step(1);
    check1("sat_done_pulse_end", done, 1'b0);
    step(8);
    check8("sat_hold_ss", ss, 8'h59);
    go(0, 0, 1, 0);

    // Pause/resume and priority
    up = 1'b1; go(1, 0, 0, 0); step(3);
    go(0, 1, 0, 0);
    check8("stop_on_tick_ss", ss, 8'h00);
    check1("stop_on_tick_running", running, 1'b0);
    up = 1'b0; go(1, 0, 0, 0);
    check1("resume_running", running, 1'b1);
    step(4);
    check8("resume_up_ss", ss, 8'h01);
    go(1, 1, 0, 0);
    check1("start_stop_pause", running, 1'b0);
    go(1, 0, 0, 0);
    load(8'h12, 8'h34);
    check8("load_in_run_mm", mm, 8'h00);
    check8("load_in_run_ss", ss, 8'h01);
    check1("load_in_run_running", running, 1'b1);

    // Clear mid-run, clamping, down start at zero
    go(0, 0, 1, 0);
    check8("clear_ss", ss, 8'h00);
    check1("clear_running", running, 1'b0);
    load(8'hAF, 8'h7C);
    check8("clamp_mm", mm, 8'h99);
    check8("clamp_ss", ss, 8'h59);
    go(0, 0, 1, 0);
    up = 1'b0; go(1, 0, 0, 0);
    check1("zero_down_done", done, 1'b1);
    check1("zero_down_running", running, 1'b0);
    step(1);
    check1("zero_down_done_end", done, 1'b0);

    // Reset in the middle of a run
    go(0, 0, 1, 0);
    up = 1'b1; go(1, 0, 0, 0); step(6);
    reset = 1'b1; step(1); reset = 1'b0;
    check8("midrun_reset_ss", ss, 8'h00);
    check1("midrun_reset_running", running, 1'b0);
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
